pk_unpacker: RTL and testbench
==============================

Name: pk_unpacker

Overview:
- Inverse of the public-key packer: accepts a packed Dilithium public key bus (rho || t1) and emits rho plus the t1 coefficients as a 10-bit valid/ready stream.
- Sits on the verify/sign side, feeding t1 into the NTT/expand path.
- Supports K = 4/6/8 (Dilithium2/3/5) with a single shared datapath.

Parameters:
- N, 256, coefficients per polynomial
- T1_W, 10, bits per t1 coefficient
- RHO_W, 256, seed width
- K_MAX, 8, maximum polynomial count
- PK_W, RHO_W + K_MAX*N*T1_W = 20736, packed bus width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start_unpack  in  1  one-cycle start pulse; bus and k_mode sampled on this cycle
- k_mode  in  4  polynomial count; legal values 4, 6, 8
- i_pk_bus  in  PK_W  packed key: rho at [255:0]; coefficient j of poly i at [256+(i*N+j)*10 +: 10]; bits above the K-mode length are don't-care
- o_rho  out  RHO_W  unpacked seed
- o_rho_valid  out  1  level; high from the cycle after an accepted start until the next accepted start
- t1_valid  out  1  coefficient available
- t1_ready  in  1  downstream accepts
- t1_data  out  T1_W  coefficient value
- t1_poly_idx  out  3  polynomial index of t1_data
- t1_coef_idx  out  8  coefficient index of t1_data
- o_busy  out  1  high whenever state != IDLE
- o_unpack_done  out  1  one-cycle pulse after the last transfer
- o_err  out  1  one-cycle pulse on a start with illegal k_mode

Behaviour:
- Clock and reset: one clock, clk; rst_n is asynchronous and active-low. Reset clears every output, register, counter and the shift register to 0, and sets state to IDLE. Reset mid-stream abandons the transfer, and no done pulse is issued.
- FSM states: IDLE, RHO, STREAM, DONE.
- IDLE, start_unpack with k_mode ∈ {4, 6, 8}:
  - Capture i_pk_bus[255:0] into o_rho.
  - Load i_pk_bus[PK_W-1:256] into the internal t1 shift register.
  - Latch k, clear counters, deassert o_rho_valid.
  - Go to RHO.
- IDLE, start_unpack with an illegal k_mode: pulse o_err; stay in IDLE; o_rho and o_rho_valid are unchanged.
- RHO: assert o_rho_valid (level); go to STREAM.
- STREAM:
  - t1_valid = 1.
  - t1_data = shift register [9:0].
  - Indices come from the poly/coef counters.
  - Transfer occurs when t1_valid & t1_ready. On a transfer:
    - The shift register shifts right by T1_W.
    - coef_idx increments. On wrap 255→0, poly_idx increments.
  - A transfer with poly_idx == k-1 and coef_idx == 255 moves the FSM to DONE.
- DONE: pulse o_unpack_done; t1_valid = 0; go to IDLE.
- Stall rules:
  - While t1_ready is low, t1_data and the indices stay stable.
  - t1_valid never depends combinationally on t1_ready.
  - t1_valid, once high, stays high until the transfer.
- Latency, start at cycle 0 with ready held high:
  - o_rho_valid at cycle 1.
  - First t1_valid at cycle 2.
  - Last transfer at cycle 1+K*256.
  - o_unpack_done at cycle 2+K*256 (K=4 gives cycle 1026).
- start_unpack while o_busy is ignored; no o_err is raised.
- Data outputs outside STREAM: t1_data and the indices are 0.
- Arithmetic: counters are unsigned. Coefficient values pass through raw with no sign or range manipulation.

Decomposition:
- Package dilithium_pk_pkg holds:
  - N, T1_W, RHO_W, K_MAX, PK_W.
  - Per-mode constants: K values and PK byte lengths 1312/1952/2592.
  - The FSM state enum.
  - Shared with pk_packer.
- No sub-module: shift register, counters and FSM stay in one module.

Test Plan:
- Round trip, K=4: pk_packer output (random rho, t1 = (i*256+j) mod 1024) → unpacker with ready=1 → rho matches; 1024 coefficients in order with correct indices; done at cycle 1026.
- K=8 boundary: bus[20735:20726]=10'h3FF, bus[265:256]=10'h155 → first t1_data 10'h155 with indices (0,0); last t1_data 10'h3FF with indices (7,255); exactly 2048 transfers.
- Backpressure, K=6: random t1_ready at 30% duty → data and indices are stable while stalled; 1536 transfers; sequence identical to the ready=1 run.
- Illegal k_mode=5 in IDLE → o_err pulse for 1 cycle; o_busy stays 0; no t1_valid.
- start_unpack re-asserted mid-STREAM → ignored; stream continues unchanged.
- rst_n low at coefficient 300 (K=4) → all outputs 0 immediately; no done pulse; a fresh start completes normally.

Source files
------------

// File: rtl/dilithium_pk_pkg.sv
// dilithium_pk_pkg: shared Dilithium public-key geometry, per-mode constants and
// the pack/unpack FSM state type.
package dilithium_pk_pkg;
    localparam int N     = 256;
    localparam int T1_W  = 10;
    localparam int RHO_W = 256;
    localparam int K_MAX = 8;
    localparam int PK_W  = RHO_W + K_MAX * N * T1_W;

    localparam logic [3:0] K_D2 = 4'd4;
    localparam logic [3:0] K_D3 = 4'd6;
    localparam logic [3:0] K_D5 = 4'd8;

    localparam int PK_BYTES_D2 = 1312;
    localparam int PK_BYTES_D3 = 1952;
    localparam int PK_BYTES_D5 = 2592;

    typedef enum logic [1:0] {IDLE, RHO, STREAM, DONE} pk_state_e;

    function automatic logic k_legal(input logic [3:0] k);
        return (k == K_D2) || (k == K_D3) || (k == K_D5);
    endfunction
endpackage

// File: rtl/pk_unpacker.sv
// pk_unpacker: splits a packed public key (rho || t1) into rho and a
// valid/ready stream of 10-bit t1 coefficients, for K = 4/6/8.
module pk_unpacker
    import dilithium_pk_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_unpack,
    input  logic [3:0]        k_mode,
    input  logic [PK_W-1:0]   i_pk_bus,
    output logic [RHO_W-1:0]  o_rho,
    output logic              o_rho_valid,
    output logic              t1_valid,
    input  logic              t1_ready,
    output logic [T1_W-1:0]   t1_data,
    output logic [2:0]        t1_poly_idx,
    output logic [7:0]        t1_coef_idx,
    output logic              o_busy,
    output logic              o_unpack_done,
    output logic              o_err
);
    localparam int SR_W = PK_W - RHO_W;

    pk_state_e         state_q, state_d;
    logic [RHO_W-1:0]  rho_q, rho_d;
    logic              rho_valid_q, rho_valid_d;
    logic [SR_W-1:0]   sr_q, sr_d;
    logic [3:0]        k_q, k_d;
    logic [2:0]        poly_q, poly_d;
    logic [7:0]        coef_q, coef_d;
    logic              err_q, err_d;
    logic              last;

    always_comb begin
        state_d     = state_q;
        rho_d       = rho_q;
        rho_valid_d = rho_valid_q;
        sr_d        = sr_q;
        k_d         = k_q;
        poly_d      = poly_q;
        coef_d      = coef_q;
        err_d       = 1'b0;
        last        = ({1'b0, poly_q} == k_q - 4'd1) && (coef_q == 8'hFF);
        case (state_q)
            IDLE: begin
                if (start_unpack && k_legal(k_mode)) begin
                    rho_d       = i_pk_bus[RHO_W-1:0];
                    sr_d        = i_pk_bus[PK_W-1:RHO_W];
                    k_d         = k_mode;
                    poly_d      = '0;
                    coef_d      = '0;
                    rho_valid_d = 1'b0;
                    state_d     = RHO;
                end else if (start_unpack) begin
                    err_d = 1'b1;
                end
            end
            RHO: begin
                rho_valid_d = 1'b1;
                state_d     = STREAM;
            end
            STREAM: begin
                if (t1_ready) begin
                    sr_d   = sr_q >> T1_W;
                    coef_d = coef_q + 8'd1;
                    poly_d = (coef_q == 8'hFF) ? poly_q + 3'd1 : poly_q;
                    state_d = last ? DONE : STREAM;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rho_q       <= '0;
            rho_valid_q <= 1'b0;
            sr_q        <= '0;
            k_q         <= '0;
            poly_q      <= '0;
            coef_q      <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rho_q       <= rho_d;
            rho_valid_q <= rho_valid_d;
            sr_q        <= sr_d;
            k_q         <= k_d;
            poly_q      <= poly_d;
            coef_q      <= coef_d;
            err_q       <= err_d;
        end
    end

    // rho is already captured while in RHO, so the valid level starts there
    assign o_rho         = rho_q;
    assign o_rho_valid   = rho_valid_q || (state_q == RHO);
    assign t1_valid      = (state_q == STREAM);
    assign t1_data       = t1_valid ? sr_q[T1_W-1:0] : '0;
    assign t1_poly_idx   = t1_valid ? poly_q : '0;
    assign t1_coef_idx   = t1_valid ? coef_q : '0;
    assign o_busy        = (state_q != IDLE);
    assign o_unpack_done = (state_q == DONE);
    assign o_err         = err_q;
endmodule

// File: tb/tb_pk_unpacker.sv
// tb_pk_unpacker: directed scoreboard bench for pk_unpacker covering round trip,
// mode boundaries, backpressure, illegal mode, ignored restart and mid-stream reset.
module tb_pk_unpacker;
    import dilithium_pk_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start_unpack = 1'b0;
    logic [3:0]        k_mode = '0;
    logic [PK_W-1:0]   i_pk_bus = '0;
    logic              t1_ready = 1'b0;
    logic [RHO_W-1:0]  o_rho;
    logic              o_rho_valid, t1_valid, o_busy, o_unpack_done, o_err;
    logic [T1_W-1:0]   t1_data;
    logic [2:0]        t1_poly_idx;
    logic [7:0]        t1_coef_idx;

    pk_unpacker dut (
        .clk(clk), .rst_n(rst_n), .start_unpack(start_unpack), .k_mode(k_mode),
        .i_pk_bus(i_pk_bus), .o_rho(o_rho), .o_rho_valid(o_rho_valid),
        .t1_valid(t1_valid), .t1_ready(t1_ready), .t1_data(t1_data),
        .t1_poly_idx(t1_poly_idx), .t1_coef_idx(t1_coef_idx), .o_busy(o_busy),
        .o_unpack_done(o_unpack_done), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] p;
        logic [7:0] c;
        logic [9:0] d;
    } exp_t;

    int               total = 0;
    int               bad = 0;
    exp_t             sb[$];
    logic [9:0]       vals [0:2047];
    logic [RHO_W-1:0] exp_rho = '0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // mode 0: (i*256+j) mod 1024, 1: random with K=8 corner values, 2: random
    task automatic build(input int mode);
        logic [9:0] v;
        exp_rho = {$urandom(), $urandom(), $urandom(), $urandom(),
                   $urandom(), $urandom(), $urandom(), $urandom()};
        i_pk_bus[RHO_W-1:0] = exp_rho;
        for (int i = 0; i < K_MAX; i++) begin
            for (int j = 0; j < N; j++) begin
                v = (mode == 0) ? 10'((i * 256 + j) % 1024) : 10'($urandom_range(0, 1023));
                if (mode == 1 && i == 0 && j == 0) v = 10'h155;
                if (mode == 1 && i == 7 && j == 255) v = 10'h3FF;
                vals[i * 256 + j] = v;
                i_pk_bus[RHO_W + (i * 256 + j) * T1_W +: T1_W] = v;
            end
        end
    endtask

    task automatic fill(input int k);
        sb.delete();
        for (int idx = 0; idx < k * 256; idx++)
            sb.push_back({3'(idx / 256), 8'(idx % 256), vals[idx]});
    endtask

    task automatic run(input int k, input int pct, input bit poke, input int rst_at, input string tag);
        int   cyc, n, done_cyc;
        bit   prev_stall, first_seen, done_after_rst;
        exp_t cur, prev;
        fill(k);
        @(negedge clk);
        k_mode = 4'(k);
        start_unpack = 1'b1;
        @(negedge clk);
        start_unpack = 1'b0;
        cyc = 1;
        chk({tag, "_rho_valid_c1"}, 256'(o_rho_valid), 256'(1));
        chk({tag, "_rho"}, o_rho, exp_rho);
        chk({tag, "_busy_c1"}, 256'(o_busy), 256'(1));
        chk({tag, "_valid_c1"}, 256'(t1_valid), 256'(0));
        n = 0;
        done_cyc = -1;
        prev_stall = 1'b0;
        first_seen = 1'b0;
        prev = '0;
        while (done_cyc < 0 && cyc < 20000) begin
            t1_ready = ($urandom_range(0, 99) < pct);
            if (t1_valid) begin
                cur = {t1_poly_idx, t1_coef_idx, t1_data};
                if (!first_seen) chk({tag, "_first_valid_cyc"}, 256'(cyc), 256'(2));
                first_seen = 1'b1;
                if (prev_stall) chk({tag, "_stall_hold"}, 256'(cur), 256'(prev));
                if (sb.size() == 0) chk({tag, "_extra_xfer"}, 256'(n), 256'(k * 256));
                else if (t1_ready) begin
                    chk({tag, "_xfer"}, 256'(cur), 256'(sb.pop_front()));
                    n++;
                end
                prev_stall = !t1_ready;
                prev = cur;
            end else prev_stall = 1'b0;
            if (poke && cyc == 100) begin
                start_unpack = 1'b1;
                k_mode = 4'd8;
                i_pk_bus = ~i_pk_bus;
            end else start_unpack = 1'b0;
            if (poke && (cyc == 101 || cyc == 102)) begin
                chk({tag, "_poke_no_err"}, 256'(o_err), 256'(0));
                chk({tag, "_poke_rho"}, o_rho, exp_rho);
            end
            if (rst_at > 0 && n == rst_at) begin
                rst_n = 1'b0;
                #1;
                chk({tag, "_rst_valid"}, 256'(t1_valid), 256'(0));
                chk({tag, "_rst_busy"}, 256'(o_busy), 256'(0));
                chk({tag, "_rst_rho_valid"}, 256'(o_rho_valid), 256'(0));
                chk({tag, "_rst_rho"}, o_rho, 256'(0));
                chk({tag, "_rst_outs"}, 256'({t1_data, t1_poly_idx, t1_coef_idx, o_unpack_done, o_err}), 256'(0));
                @(negedge clk);
                rst_n = 1'b1;
                done_after_rst = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    done_after_rst = done_after_rst | o_unpack_done | t1_valid;
                end
                chk({tag, "_no_done_after_rst"}, 256'(done_after_rst), 256'(0));
                sb.delete();
                return;
            end
            if (o_unpack_done) begin
                done_cyc = cyc;
                chk({tag, "_done_no_valid"}, 256'(t1_valid), 256'(0));
            end
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_done_seen"}, 256'(done_cyc >= 0), 256'(1));
        if (pct == 100) chk({tag, "_done_cyc"}, 256'(done_cyc), 256'(2 + k * 256));
        chk({tag, "_xfer_count"}, 256'(n), 256'(k * 256));
        chk({tag, "_sb_empty"}, 256'(sb.size()), 256'(0));
        chk({tag, "_done_pulse_end"}, 256'(o_unpack_done), 256'(0));
        chk({tag, "_idle_after"}, 256'(o_busy), 256'(0));
        chk({tag, "_rho_valid_hold"}, 256'(o_rho_valid), 256'(1));
        t1_ready = 1'b0;
    endtask

    initial begin
        #1;
        chk("reset_busy", 256'(o_busy), 256'(0));
        chk("reset_rho", o_rho, 256'(0));
        chk("reset_outs", 256'({o_rho_valid, t1_valid, t1_data, t1_poly_idx, t1_coef_idx, o_unpack_done, o_err}), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        build(0);
        run(4, 100, 1'b1, 0, "k4_roundtrip");

        build(1);
        run(8, 100, 1'b0, 0, "k8_boundary");

        build(2);
        run(6, 100, 1'b0, 0, "k6_ready1");
        run(6, 30, 1'b0, 0, "k6_backpressure");

        build(0);
        run(4, 100, 1'b0, 300, "k4_reset");
        build(2);
        run(4, 100, 1'b0, 0, "k4_after_reset");

        @(negedge clk);
        k_mode = 4'd5;
        start_unpack = 1'b1;
        @(negedge clk);
        start_unpack = 1'b0;
        chk("illegal_err", 256'(o_err), 256'(1));
        chk("illegal_busy", 256'(o_busy), 256'(0));
        chk("illegal_valid", 256'(t1_valid), 256'(0));
        chk("illegal_rho", o_rho, exp_rho);
        chk("illegal_rho_valid", 256'(o_rho_valid), 256'(1));
        @(negedge clk);
        chk("illegal_err_end", 256'(o_err), 256'(0));
        chk("illegal_busy_end", 256'(o_busy), 256'(0));
        chk("illegal_valid_end", 256'(t1_valid), 256'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
